se_pair_leak_monitor: RTL and testbench
=======================================

// Module: se_pair_leak_monitor
// PURPOSE
//   Downstream checker for a pair of SE instances run in self-composition on identical inputs.
//   Consumes both output handshakes and measures completion skew between the two copies.
//   Latches sticky timing-leak, mismatch and timeout evidence for the formal/sim harness.
//   Replaces the purely combinational validOne/validTwo comparison with cycle-accurate skew tracking.
// PARAMETERS
//   DATA_W    128  width of each SE result
//   SKEW_W    8    width of skew counter and of leakCount
//   MAX_SKEW  200  cycles waiting for the second copy before timeout (must be < 2**SKEW_W)
// PORTS
//   clock           in   1       system clock
//   reset           in   1       synchronous, active-high reset
//   io_validOne     in   1       SE copy 1 io_out_valid
//   io_resultOne    in   DATA_W  SE copy 1 io_out_result
//   io_validTwo     in   1       SE copy 2 io_out_valid
//   io_resultTwo    in   DATA_W  SE copy 2 io_out_result
//   io_out_ready    in   1       shared ready driven to both SE copies
//   io_clear        in   1       clears sticky flags and counters
//   busy            out  1       one copy has completed, other outstanding
//   timingLeak      out  1       sticky: some pair completed with nonzero skew
//   leakSkew        out  SKEW_W  skew (cycles) of most recent skewed pair
//   leakCount       out  SKEW_W  number of skewed pairs, saturating at all-ones
//   pairCount       out  SKEW_W  number of completed pairs (skewed or not), saturating
//   timeout         out  1       sticky: second copy absent for MAX_SKEW cycles
//   resultMismatch  out  1       sticky: paired results differ (RESULT_CMP_EN only)
// BEHAVIOUR
//   - fireOne = io_validOne & io_out_ready; fireTwo likewise. Monitor never backpressures.
//   - Reset: all outputs 0, FSM IDLE, skew counter 0, held result 0.
//   - FSM states IDLE, WAIT_TWO (copy1 done), WAIT_ONE (copy2 done):
//     IDLE: fireOne&fireTwo -> pair done, skew 0, stay IDLE; fireOne only -> WAIT_TWO;
//           fireTwo only -> WAIT_ONE; first fire stores its result, skew counter <= 1.
//     WAIT_x: counter +1 per cycle; matching fire -> pair done with skew = counter, -> IDLE.
//     Repeat fire from the already-completed copy while WAIT_x: ignored (not counted).
//     Counter == MAX_SKEW with no matching fire: timeout <= 1, -> IDLE, no pair counted.
//   - Pair done: pairCount +1; if skew != 0: timingLeak <= 1, leakSkew <= skew,
//     leakCount +1 (saturating). All updates visible the cycle after the completing fire.
//   - busy = (state != IDLE), registered from state, no combinational input path.
//   - io_clear: highest priority after reset; FSM -> IDLE, all flags/counters 0, fire in
//     same cycle discarded. Reset mid-WAIT likewise abandons the pending pair.
//   - Counters are plain unsigned; saturation at {SKEW_W{1'b1}}, never wrap.
// CONFIGURATION
//   SE_MON_RESULT_CMP_EN defined: held/incoming results compared on pair done (skew-0 pairs
//     compare resultOne vs resultTwo directly); any difference sets resultMismatch sticky.
//   Not defined: no result storage, resultMismatch tied 0, DATA_W inputs unused.
// STRUCTURE
//   se_mon_pkg: state enum (IDLE/WAIT_ONE/WAIT_TWO), SKEW_W default, saturate-increment function.
//   One sub-module: se_sat_counter (width param, inc, clr -> saturating count); used for
//   pairCount and leakCount. Skew counter and FSM inline in top.
// TESTING
//   1. Both valid+ready in cycle 5 -> pairCount=1, timingLeak=0, busy never 1.
//   2. validOne cycle 5, validTwo cycle 8 (ready high) -> busy 6..8, leakSkew=3,
//      leakCount=1, timingLeak=1 from cycle 9.
//   3. validTwo only, held 210 cycles (MAX_SKEW=200) -> timeout=1 at cycle 201 after fire,
//      pairCount=0, FSM IDLE.
//   4. Skew pair then io_clear, then fire in same cycle as clear -> all outputs 0, busy 0.
//   5. RESULT_CMP_EN: results 0x5 and 0x6 paired with skew 0 -> resultMismatch=1,
//      timingLeak=0; without macro resultMismatch stays 0.
//   6. 300 skewed pairs -> leakCount and pairCount saturate at 255.

Source files
------------

// File: rtl/se_mon_pkg.sv
// Shared types and helpers for the SE self-composition pair monitor.
package se_mon_pkg;

    localparam int SE_MON_SKEW_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ONE = 2'd1,
        ST_WAIT_TWO = 2'd2
    } se_mon_state_e;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        if (width >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (val >= max_v) begin
            return max_v;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/se_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
module se_sat_counter
    import se_mon_pkg::*;
#(
    parameter int W = SE_MON_SKEW_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = W'(sat_inc(32'(count_q), W));
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/se_pair_leak_monitor.sv
// Completion-skew monitor for two SE copies run on identical inputs.
// Optional result comparison is enabled by defining SE_MON_RESULT_CMP_EN.
module se_pair_leak_monitor
    import se_mon_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int SKEW_W   = SE_MON_SKEW_W,
    parameter int MAX_SKEW = 200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_validOne,
    input  logic [DATA_W-1:0] io_resultOne,
    input  logic              io_validTwo,
    input  logic [DATA_W-1:0] io_resultTwo,
    input  logic              io_out_ready,
    input  logic              io_clear,
    output logic              busy,
    output logic              timingLeak,
    output logic [SKEW_W-1:0] leakSkew,
    output logic [SKEW_W-1:0] leakCount,
    output logic [SKEW_W-1:0] pairCount,
    output logic              timeout,
    output logic              resultMismatch
);

    se_mon_state_e     state_q, state_d;
    logic [SKEW_W-1:0] skew_q, skew_d;
    logic              busy_q, timing_leak_q, timeout_q;
    logic [SKEW_W-1:0] leak_skew_q;

    logic              fire_one_s, fire_two_s;
    logic              pair_done_s, timeout_set_s, leak_inc_s;
    logic [SKEW_W-1:0] pair_skew_s;

    assign fire_one_s = io_validOne & io_out_ready;
    assign fire_two_s = io_validTwo & io_out_ready;
    assign leak_inc_s = pair_done_s & (pair_skew_s != '0);

    // Pairing FSM with skew counter; a repeat fire from the finished copy is ignored.
    always_comb begin
        state_d       = state_q;
        skew_d        = skew_q;
        pair_done_s   = 1'b0;
        pair_skew_s   = '0;
        timeout_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire_one_s && fire_two_s) begin
                    pair_done_s = 1'b1;
                end else if (fire_one_s) begin
                    state_d = ST_WAIT_TWO;
                    skew_d  = SKEW_W'(1);
                end else if (fire_two_s) begin
                    state_d = ST_WAIT_ONE;
                    skew_d  = SKEW_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_TWO: begin
                if (fire_two_s) begin
                    pair_done_s = 1'b1;
                    pair_skew_s = skew_q;
                    state_d     = ST_IDLE;
                    skew_d      = '0;
                end else if (skew_q == SKEW_W'(MAX_SKEW)) begin
                    timeout_set_s = 1'b1;
                    state_d       = ST_IDLE;
                    skew_d        = '0;
                end else begin
                    skew_d = skew_q + SKEW_W'(1);
                end
            end
            ST_WAIT_ONE: begin
                if (fire_one_s) begin
                    pair_done_s = 1'b1;
                    pair_skew_s = skew_q;
                    state_d     = ST_IDLE;
                    skew_d      = '0;
                end else if (skew_q == SKEW_W'(MAX_SKEW)) begin
                    timeout_set_s = 1'b1;
                    state_d       = ST_IDLE;
                    skew_d        = '0;
                end else begin
                    skew_d = skew_q + SKEW_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                skew_d  = '0;
            end
        endcase
        if (io_clear) begin
            state_d       = ST_IDLE;
            skew_d        = '0;
            pair_done_s   = 1'b0;
            pair_skew_s   = '0;
            timeout_set_s = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, skew counter and sticky evidence registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            skew_q        <= '0;
            busy_q        <= 1'b0;
            timing_leak_q <= 1'b0;
            timeout_q     <= 1'b0;
            leak_skew_q   <= '0;
        end else begin
            state_q <= state_d;
            skew_q  <= skew_d;
            busy_q  <= (state_d != ST_IDLE);
            if (io_clear) begin
                timing_leak_q <= 1'b0;
                timeout_q     <= 1'b0;
                leak_skew_q   <= '0;
            end else begin
                if (timeout_set_s) begin
                    timeout_q <= 1'b1;
                end
                if (leak_inc_s) begin
                    timing_leak_q <= 1'b1;
                    leak_skew_q   <= pair_skew_s;
                end
            end
        end
    end

    se_sat_counter #(.W(SKEW_W)) u_pair_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (io_clear),
        .inc_i   (pair_done_s),
        .count_o (pairCount)
    );

    se_sat_counter #(.W(SKEW_W)) u_leak_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (io_clear),
        .inc_i   (leak_inc_s),
        .count_o (leakCount)
    );

`ifdef SE_MON_RESULT_CMP_EN
    logic [DATA_W-1:0] held_q, held_d;
    logic              mismatch_q, mismatch_s;

    // Hold the first-finishing result; compare it against the partner on pair done.
    always_comb begin
        held_d     = held_q;
        mismatch_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire_one_s && fire_two_s) begin
                    mismatch_s = (io_resultOne != io_resultTwo);
                end else if (fire_one_s) begin
                    held_d = io_resultOne;
                end else if (fire_two_s) begin
                    held_d = io_resultTwo;
                end else begin
                    held_d = held_q;
                end
            end
            ST_WAIT_TWO: begin
                if (fire_two_s) begin
                    mismatch_s = (held_q != io_resultTwo);
                end else begin
                    mismatch_s = 1'b0;
                end
            end
            ST_WAIT_ONE: begin
                if (fire_one_s) begin
                    mismatch_s = (held_q != io_resultOne);
                end else begin
                    mismatch_s = 1'b0;
                end
            end
            default: begin
                mismatch_s = 1'b0;
            end
        endcase
    end

    // Held result and sticky mismatch flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_q     <= '0;
            mismatch_q <= 1'b0;
        end else if (io_clear) begin
            held_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            held_q <= held_d;
            if (mismatch_s) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign resultMismatch = mismatch_q;
`else
    logic unused_s;
    assign unused_s       = ^{io_resultOne, io_resultTwo};
    assign resultMismatch = 1'b0;
`endif

    assign busy       = busy_q;
    assign timingLeak = timing_leak_q;
    assign leakSkew   = leak_skew_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_se_pair_leak_monitor.sv
// Scoreboard bench for se_pair_leak_monitor: directed stimulus pushes expected snapshots,
// a negedge monitor pops and compares them at their due cycle.
module tb_se_pair_leak_monitor;

    localparam int DATA_W = 128;
    localparam int SKEW_W = 8;
    localparam int MM_EXP =
`ifdef SE_MON_RESULT_CMP_EN
        1;
`else
        0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              io_validOne, io_validTwo, io_out_ready, io_clear;
    logic [DATA_W-1:0] io_resultOne, io_resultTwo;
    logic              busy, timingLeak, timeout, resultMismatch;
    logic [SKEW_W-1:0] leakSkew, leakCount, pairCount;

    se_pair_leak_monitor #(.DATA_W(DATA_W), .SKEW_W(SKEW_W), .MAX_SKEW(200)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_validOne    (io_validOne),
        .io_resultOne   (io_resultOne),
        .io_validTwo    (io_validTwo),
        .io_resultTwo   (io_resultTwo),
        .io_out_ready   (io_out_ready),
        .io_clear       (io_clear),
        .busy           (busy),
        .timingLeak     (timingLeak),
        .leakSkew       (leakSkew),
        .leakCount      (leakCount),
        .pairCount      (pairCount),
        .timeout        (timeout),
        .resultMismatch (resultMismatch)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          when;
        string       name;
        logic [30:0] vec;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected snapshot for the cycle after the next clock edge.
    task automatic exp_at(input string nm, input int b, input int lk, input int sk,
                          input int lc, input int pc, input int to, input int mm);
        exp_t e;
        e.when = cyc + 1;
        e.name = nm;
        e.vec  = {1'(b), 1'(lk), 8'(sk), 8'(lc), 8'(pc), 1'(to), 1'(mm), 3'b000};
        q.push_back(e);
    endtask

    task automatic drive(input int v1, input int v2, input int rdy, input int clr);
        io_validOne  = 1'(v1);
        io_validTwo  = 1'(v2);
        io_out_ready = 1'(rdy);
        io_clear     = 1'(clr);
        @(negedge clock);
    endtask

    // Monitor: compare every expectation that has come due.
    always @(negedge clock) begin
        logic [30:0] act;
        act = {busy, timingLeak, leakSkew, leakCount, pairCount, timeout, resultMismatch, 3'b000};
        while (q.size() > 0 && q[0].when <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (e.when != cyc) begin
                n_fail++;
                $display("FAIL %s: checked at cycle %0d, due at cycle %0d", e.name, cyc, e.when);
            end else if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s: got busy=%0b leak=%0b skew=%0d lcnt=%0d pcnt=%0d to=%0b mm=%0b, expected busy=%0b leak=%0b skew=%0d lcnt=%0d pcnt=%0d to=%0b mm=%0b",
                         e.name, act[30], act[29], act[28:21], act[20:13], act[12:5], act[4], act[3],
                         e.vec[30], e.vec[29], e.vec[28:21], e.vec[20:13], e.vec[12:5], e.vec[4], e.vec[3]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stim_done=%0b, required 1", stim_done);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        io_resultOne = 128'h5;
        io_resultTwo = 128'h5;
        drive(1, 1, 1, 0);
        drive(1, 0, 1, 0);
        exp_at("reset", 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0);
        reset = 1'b0;
        drive(0, 0, 1, 0);

        // Both copies complete together: no skew.
        exp_at("t1_both", 0, 0, 0, 0, 1, 0, 0);
        drive(1, 1, 1, 0);
        exp_at("t1_noready", 0, 0, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0);

        // Copy one first, copy two three cycles later, repeat fire in between.
        exp_at("t2_fire1", 1, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 1, 0);
        drive(0, 0, 1, 0);
        exp_at("t2_repeat", 1, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 1, 0);
        exp_at("t2_pair", 0, 1, 3, 1, 2, 0, 0);
        drive(0, 1, 1, 0);

        // Copy two alone: timeout after MAX_SKEW cycles.
        exp_at("t3_fire2", 1, 1, 3, 1, 2, 0, 0);
        drive(0, 1, 1, 0);
        repeat (198) drive(0, 0, 1, 0);
        exp_at("t3_edge", 1, 1, 3, 1, 2, 0, 0);
        drive(0, 0, 1, 0);
        exp_at("t3_timeout", 0, 1, 3, 1, 2, 1, 0);
        drive(0, 0, 1, 0);
        exp_at("t3_idle", 0, 1, 3, 1, 2, 1, 0);
        drive(0, 0, 1, 0);

        // Skew-0 pair with differing results.
        io_resultTwo = 128'h6;
        exp_at("t5_cmp", 0, 1, 3, 1, 3, 1, MM_EXP);
        drive(1, 1, 1, 0);
        io_resultTwo = 128'h5;

        // Skew-1 pair, then clear while a pair is pending with a same-cycle fire.
        exp_at("t4_fire1", 1, 1, 3, 1, 3, 1, MM_EXP);
        drive(1, 0, 1, 0);
        exp_at("t4_pair", 0, 1, 1, 2, 4, 1, MM_EXP);
        drive(0, 1, 1, 0);
        exp_at("t4_pend", 1, 1, 1, 2, 4, 1, MM_EXP);
        drive(1, 0, 1, 0);
        exp_at("t4_clear", 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1);
        exp_at("t4_after", 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0);

        // 300 skew-1 pairs: both counters saturate at 255.
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 1, 0);
            if (i == 253) exp_at("t6_254", 0, 1, 1, 254, 254, 0, 0);
            if (i == 254) exp_at("t6_255", 0, 1, 1, 255, 255, 0, 0);
            if (i == 299) exp_at("t6_sat", 0, 1, 1, 255, 255, 0, 0);
            drive(0, 1, 1, 0);
        end

        repeat (3) drive(0, 0, 1, 0);
        stim_done = 1'b1;
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
